// File: rtl/enc_pkg.sv
// ============================================================================
// Module      : enc_pkg
// Description : Shared definitions for the 8-to-3 request encoder and for
//               decoder-side blocks that use the same index format.
//               - N_REQ / IDX_W : request count and index width
//               - state_t       : encoder control states
//               - onehot8()     : index -> one-hot mask
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick8.sv
// ============================================================================
// Module      : prio_pick8
// Description : Combinational 8-way priority picker.
//               rr_en = 0 : highest set bit wins.
//               rr_en = 1 : search last-1, last-2, ... wrapping, ending at
//                           last; the first set bit in that order wins.
// Ports       : vec   [7:0] in  - candidate vector
//               last  [2:0] in  - previously granted index (rotating mode)
//               rr_en       in  - select rotating priority
//               idx   [2:0] out - picked index (0 when vec is empty)
//               any         out - vec has at least one bit set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick8
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] last,
  input  logic             rr_en,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |vec;
    if (rr_en) begin
      // Walk from the lowest-priority slot (last) towards the highest
      // (last-1) so that later, higher-priority hits overwrite earlier ones.
      for (int k = N_REQ; k >= 1; k--) begin
        cand = last - IDX_W'(k);
        if (vec[cand]) begin
          idx = cand;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_encoder_8to3.sv
// ============================================================================
// Module      : req_encoder_8to3
// Description : Sequential 8-to-3 request encoder. Requests are captured into
//               a sticky pending register; one at a time is encoded and
//               presented on a valid/ready port. Fixed or rotating priority.
// Ports       : clk              in  - clock, rising edge
//               rst              in  - asynchronous active-high reset
//               req_i      [7:0] in  - request lines
//               clr_i      [7:0] in  - cancel pending lines
//               out_ready        in  - consumer accepts presented index
//               out_valid        out - out_idx holds a granted request
//               out_idx    [2:0] out - granted line index (registered)
//               pending_o  [7:0] out - pending register
//               overflow_o       out - request hit an already-pending bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_encoder_8to3
  import enc_pkg::*;
#(
  parameter bit RR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] clr_i,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending_o,
  output logic             overflow_o
);

  state_t           state;
  logic [N_REQ-1:0] pending;
  logic [IDX_W-1:0] last;
  logic             overflow;

  logic             accept;
  logic [N_REQ-1:0] acc_mask;
  logic [N_REQ-1:0] rem;
  logic [IDX_W-1:0] idx_pend;
  logic [IDX_W-1:0] idx_rem;
  logic             any_pend;
  logic             any_rem;

  assign out_valid  = (state == PRESENT);
  assign pending_o  = pending;
  assign overflow_o = overflow;

  assign accept   = out_valid & out_ready;
  assign acc_mask = accept ? onehot8(out_idx) : '0;
  // Requests arriving in the accept cycle are deliberately excluded here;
  // they become visible to the picker one cycle later via the pending reg.
  assign rem      = pending & ~acc_mask & ~clr_i;

  // Picker for the first grant out of IDLE.
  prio_pick8 u_pick_pend (
    .vec   (pending),
    .last  (last),
    .rr_en (RR_MODE),
    .idx   (idx_pend),
    .any   (any_pend)
  );

  // Picker for back-to-back grants. The index being accepted becomes the
  // new 'last', so it is fed directly rather than waiting for the register.
  prio_pick8 u_pick_rem (
    .vec   (rem),
    .last  (out_idx),
    .rr_en (RR_MODE),
    .idx   (idx_rem),
    .any   (any_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out_idx  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      last     <= '0;
    end else begin
      pending  <= (pending | req_i) & ~clr_i & ~acc_mask;
      overflow <= |(req_i & pending & ~clr_i & ~acc_mask);

      if (accept) begin
        last <= out_idx;
        if (any_rem) begin
          out_idx <= idx_rem;
        end else begin
          state <= IDLE;
        end
      end else if ((state == IDLE) && any_pend) begin
        out_idx <= idx_pend;
        state   <= PRESENT;
      end
      // While PRESENT and not accepted, out_idx is held even if clr_i
      // cancels its pending bit: a presented index is never retracted.
    end
  end

endmodule

`default_nettype wire
